// File: rtl/node_pkg.sv
// node_pkg: shared widths, types, threshold defaults and clamp helper.
// Defines `W, `HI and `LO (guarded) for the node-integrator slice.
`ifndef W
`define W 16
`endif
`ifndef HI
`define HI 16384
`endif
`ifndef LO
`define LO (-16384)
`endif

package node_pkg;

  localparam int W  = `W;
  localparam int HI = `HI;
  localparam int LO = `LO;

  // wide enough for v + delta with up to 16 inputs
  localparam int VW = W + 7;

  typedef logic signed [W-1:0]  node_t;
  typedef logic signed [VW-1:0] wide_t;

  localparam int TH_HI_DEF = HI / 2;
  localparam int TH_LO_DEF = LO / 2;

  function automatic int sum_w(input int n);
    return W + $clog2(n) + 1;
  endfunction

  function automatic node_t clamp(
    input  wide_t x,
    output logic  sat
  );
    sat = 1'b1;
    if (x > wide_t'(HI)) begin
      clamp = node_t'(HI);
    end else if (x < wide_t'(LO)) begin
      clamp = node_t'(LO);
    end else begin
      clamp = x[W-1:0];
      sat   = 1'b0;
    end
  endfunction

endpackage

// File: rtl/node_current_sum.sv
// node_current_sum: sign-extends N_IN packed currents and sums them.
// Ports: i_i packed currents (slot k = [k*W +: W]), sum_o overflow-free sum.
module node_current_sum
  import node_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int SW   = sum_w(N_IN)
) (
  input  logic [N_IN*W-1:0]   i_i,
  output logic signed [SW-1:0] sum_o
);

  logic signed [SW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int k = 0; k < N_IN; k++) begin
      acc = acc + {{(SW-W){i_i[k*W+W-1]}}, i_i[k*W +: W]};
    end
  end

  assign sum_o = acc;

endmodule

// File: rtl/node_integrator.sv
// node_integrator: integrates summed node currents into a clamped voltage
// with hysteretic level d, settle and clamp flags. Option: NODE_PRECHARGE_EN.
// Ports: clk, reset (sync, high), en, [precharge], i packed currents;
// v voltage, d level, settled quiet flag, saturated clamp flag.
module node_integrator
  import node_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int CAP_SHIFT     = 2,
  parameter int INIT_V        = LO,
  parameter int TH_HI         = TH_HI_DEF,
  parameter int TH_LO         = TH_LO_DEF,
  parameter int SETTLE_TOL    = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
`ifdef NODE_PRECHARGE_EN
  input  logic              precharge,
`endif
  input  logic [N_IN*W-1:0] i,
  output logic [W-1:0]      v,
  output logic              d,
  output logic              settled,
  output logic              saturated
);

  localparam int SW = sum_w(N_IN);

  localparam node_t TH_HI_V = node_t'(TH_HI);
  localparam node_t TH_LO_V = node_t'(TH_LO);
  localparam node_t INIT_VV = node_t'(INIT_V);
  localparam logic  D_INIT  = (INIT_V > TH_HI);

  localparam logic signed [SW-1:0] TOL_P = SW'(SETTLE_TOL);
  localparam logic signed [SW-1:0] TOL_N = -TOL_P;
  localparam logic [7:0]           CYC   = 8'(SETTLE_CYCLES);

  node_t      v_q, v_d;
  logic       d_q, d_d;
  logic       set_q, set_d;
  logic       sat_q, sat_d;
  logic [7:0] cnt_q, cnt_d;

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] delta;
  logic signed [SW:0]   vraw;
  wide_t                vwide;
  node_t                v_new;
  logic                 clip;
  logic                 quiet;
  logic [7:0]           cnt_n;

  node_current_sum #(
    .N_IN (N_IN),
    .SW   (SW)
  ) u_sum (
    .i_i   (i),
    .sum_o (sum)
  );

  assign delta = sum >>> CAP_SHIFT;
  assign vraw  = {{(SW+1-W){v_q[W-1]}}, v_q}
               + {delta[SW-1], delta};
  assign vwide = {{(VW-SW-1){vraw[SW]}}, vraw};
  assign quiet = (delta <= TOL_P) && (delta >= TOL_N);

  always_comb begin
    v_new = clamp(vwide, clip);
  end

  // counter saturates so settled stays up while the node stays quiet
  always_comb begin
    cnt_n = 8'd0;
    if (quiet) begin
      cnt_n = (cnt_q == CYC) ? cnt_q : cnt_q + 8'd1;
    end
  end

  always_comb begin
    v_d   = v_q;
    d_d   = d_q;
    set_d = set_q;
    sat_d = sat_q;
    cnt_d = cnt_q;
`ifdef NODE_PRECHARGE_EN
    if (precharge) begin
      v_d   = node_t'(HI);
      d_d   = 1'b1;
      set_d = 1'b0;
      sat_d = 1'b0;
      cnt_d = 8'd0;
    end else
`endif
    if (en) begin
      v_d   = v_new;
      sat_d = clip;
      cnt_d = cnt_n;
      set_d = (cnt_n == CYC);
      if (v_new > TH_HI_V) begin
        d_d = 1'b1;
      end else if (v_new < TH_LO_V) begin
        d_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= INIT_VV;
      d_q   <= D_INIT;
      set_q <= 1'b0;
      sat_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      set_q <= set_d;
      sat_q <= sat_d;
      cnt_q <= cnt_d;
    end
  end

  assign v         = v_q;
  assign d         = d_q;
  assign settled   = set_q;
  assign saturated = sat_q;

endmodule

// File: tb/tb_node_integrator.sv
// tb_node_integrator: randomized and directed checks of node_integrator
// against a behavioural node model (W=16, HI=16384, LO=-16384).
module tb_node_integrator;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
`ifdef NODE_PRECHARGE_EN
  logic        precharge;
`endif
  logic [63:0] i;
  logic [15:0] v;
  logic        d;
  logic        settled;
  logic        saturated;

  int cur [4];

  int n_cmp = 0;
  int n_bad = 0;

  int m_v;
  int m_cnt;
  bit m_d, m_set, m_sat;

  always #5 clk = ~clk;

  always_comb begin
    i = '0;
    for (int k = 0; k < 4; k++) begin
      i[k*16 +: 16] = 16'(cur[k]);
    end
  end

  node_integrator #(
    .N_IN      (4),
    .CAP_SHIFT (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
`ifdef NODE_PRECHARGE_EN
    .precharge (precharge),
`endif
    .i         (i),
    .v         (v),
    .d         (d),
    .settled   (settled),
    .saturated (saturated)
  );

  // one rising edge of the ideal node: capacitor charge with rails
  task automatic model_edge();
    int s, dl, vr;
    if (reset) begin
      m_v = -16384; m_d = 0; m_set = 0; m_sat = 0; m_cnt = 0;
    end
`ifdef NODE_PRECHARGE_EN
    else if (precharge) begin
      m_v = 16384; m_d = 1; m_set = 0; m_sat = 0; m_cnt = 0;
    end
`endif
    else if (en) begin
      s = cur[0] + cur[1] + cur[2] + cur[3];
      dl = s / 4;
      if (s < 0 && (s % 4) != 0) dl = dl - 1;
      vr = m_v + dl;
      m_sat = (vr > 16384) || (vr < -16384);
      m_v = (vr > 16384) ? 16384 : (vr < -16384) ? -16384 : vr;
      if (m_v > 8192) m_d = 1;
      else if (m_v < -8192) m_d = 0;
      if (dl <= 1 && dl >= -1) m_cnt = (m_cnt >= 4) ? 4 : m_cnt + 1;
      else m_cnt = 0;
      m_set = (m_cnt == 4);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_i(input int a, input int b, input int c, input int e);
    cur[0] = a; cur[1] = b; cur[2] = c; cur[3] = e;
  endtask

  function automatic logic [18:0] exp_vec();
    return {16'(m_v), m_d, m_set, m_sat};
  endfunction

  task automatic drive_to(input int target);
    int n;
    en = 1;
    for (int g = 0; g < 4 && m_v != target; g++) begin
      n = target - m_v;
      if (n > 32767) n = 32767;
      if (n < -32768) n = -32768;
      set_i(n, n, n, n);
      cyc();
    end
  endtask

  task automatic test_reset();
    reset = 1; en = 1; set_i(0, 0, 0, 0);
    cyc(); cyc();
    n_cmp++;
    if ({v, d, settled, saturated} !== {16'h C000, 3'b000}) begin
      n_bad++;
      $display("FAIL reset: got v=%0d d=%b s=%b sat=%b want v=-16384 0 0 0",
               $signed(v), d, settled, saturated);
    end
    reset = 0;
  endtask

  task automatic test_zero_settle();
    en = 1; set_i(0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      n_cmp++;
      if ({v, d, settled, saturated} !== exp_vec()
          || settled !== (k >= 4)) begin
        n_bad++;
        $display("FAIL zero_settle step %0d: got %h want %h", k,
                 {v, d, settled, saturated}, exp_vec());
      end
    end
  endtask

  task automatic test_ramp();
    logic [18:0] frz;
    en = 1; set_i(400, 0, 0, 0);
    for (int k = 0; k < 250; k++) begin
      cyc();
      n_cmp++;
      if ({v, d, settled, saturated} !== exp_vec()) begin
        n_bad++;
        $display("FAIL ramp step %0d: got v=%0d d=%b want v=%0d d=%b", k,
                 $signed(v), d, m_v, m_d);
      end
    end
    frz = exp_vec();
    en = 0; set_i(-9000, 500, 7, 20000);
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_cmp++;
      if ({v, d, settled, saturated} !== frz) begin
        n_bad++;
        $display("FAIL freeze %0d: got %h want %h", k,
                 {v, d, settled, saturated}, frz);
      end
    end
  endtask

  task automatic test_clamp_hi();
    drive_to(16000);
    set_i(32767, 32767, 32767, 32767);
    cyc();
    n_cmp++;
    if (v !== 16'sd16384 || saturated !== 1'b1 || d !== 1'b1) begin
      n_bad++;
      $display("FAIL clamp_hi: got v=%0d sat=%b d=%b want 16384 1 1",
               $signed(v), saturated, d);
    end
    set_i(0, 0, 0, 0);
    cyc();
    n_cmp++;
    if ({v, d, settled, saturated} !== exp_vec() || saturated !== 1'b0) begin
      n_bad++;
      $display("FAIL clamp_hi_release: got %h want %h",
               {v, d, settled, saturated}, exp_vec());
    end
  endtask

  task automatic test_clamp_lo();
    drive_to(0);
    set_i(-32768, -32768, -32768, -32768);
    cyc();
    n_cmp++;
    if (v !== 16'hC000 || saturated !== 1'b1 || d !== 1'b0
        || {v, d, settled, saturated} !== exp_vec()) begin
      n_bad++;
      $display("FAIL clamp_lo: got v=%0d sat=%b d=%b want -16384 1 0",
               $signed(v), saturated, d);
    end
  endtask

  task automatic test_settle_alt();
    en = 1;
    for (int k = 0; k < 6; k++) begin
      set_i(0, (k % 2) ? -8 : 8, 0, 0);
      cyc();
      n_cmp++;
      if (settled !== 1'b0 || {v, d, settled, saturated} !== exp_vec()) begin
        n_bad++;
        $display("FAIL settle_alt %0d: got %h want %h", k,
                 {v, d, settled, saturated}, exp_vec());
      end
    end
    set_i(0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      n_cmp++;
      if (settled !== (k >= 4)) begin
        n_bad++;
        $display("FAIL settle_quiet %0d: got settled=%b want %b", k,
                 settled, (k >= 4));
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 1; set_i(30000, 30000, 30000, 30000);
    reset = 1;
    cyc();
    reset = 0;
    n_cmp++;
    if ({v, d, settled, saturated} !== {16'hC000, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_mid: got %h want %h",
               {v, d, settled, saturated}, {16'hC000, 3'b000});
    end
  endtask

`ifdef NODE_PRECHARGE_EN
  task automatic test_precharge();
    drive_to(0);
    precharge = 1; reset = 1;
    cyc();
    reset = 0;
    n_cmp++;
    if (v !== 16'hC000) begin
      n_bad++;
      $display("FAIL pre_reset: got v=%0d want -16384", $signed(v));
    end
    en = 1; set_i(-1000, -1000, -1000, -1000);
    cyc();
    n_cmp++;
    if ({v, d, settled, saturated} !== {16'h4000, 3'b100}) begin
      n_bad++;
      $display("FAIL precharge: got %h want %h",
               {v, d, settled, saturated}, {16'h4000, 3'b100});
    end
    precharge = 0;
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 60) == 0);
      for (int s = 0; s < 4; s++) begin
        case ($urandom_range(0, 3))
          0: cur[s] = 0;
          1: cur[s] = $urandom_range(0, 4) - 2;
          2: cur[s] = $urandom_range(0, 4000) - 2000;
          default: cur[s] = $urandom_range(0, 65535) - 32768;
        endcase
      end
`ifdef NODE_PRECHARGE_EN
      precharge = ($urandom_range(0, 40) == 0);
`endif
      cyc();
      n_cmp++;
      if ({v, d, settled, saturated} !== exp_vec()) begin
        n_bad++;
        $display("FAIL random %0d: got v=%0d d=%b s=%b sat=%b want v=%0d d=%b s=%b sat=%b",
                 k, $signed(v), d, settled, saturated, m_v, m_d, m_set, m_sat);
      end
    end
    reset = 0;
`ifdef NODE_PRECHARGE_EN
    precharge = 0;
`endif
  endtask

  initial begin
    reset = 1; en = 0; set_i(0, 0, 0, 0);
`ifdef NODE_PRECHARGE_EN
    precharge = 0;
`endif
    m_v = 0; m_cnt = 0; m_d = 0; m_set = 0; m_sat = 0;
    test_reset();
    test_zero_settle();
    test_ramp();
    test_clamp_hi();
    test_clamp_lo();
    test_settle_alt();
    test_reset_mid();
`ifdef NODE_PRECHARGE_EN
    test_precharge();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
